// File: rtl/tpu_axil_slave_regs.sv
// tpu_axil_slave_regs
//   AXI4-Lite responder for the TPU S00_AXI port. Holds NUM_REGS 32-bit
//   control/status registers, exports their contents and a one-cycle write
//   pulse per register to the TPU core.
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*       single-outstanding write channel (AW/W in any order)
//   S_AXI_AR*/R*          read channel, one-cycle latency
//   reg_q                 flattened register contents, reg i at [32i+31:32i]
//   reg_wr_pulse          bit i high for one cycle after reg i is written
module tpu_axil_slave_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic                    aw_held;
  logic [IDX_W-1:0]        aw_idx_q;
  logic                    w_held;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;

  logic                    bvalid_q;
  resp_t                   bresp_q;
  logic                    rvalid_q;
  resp_t                   rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Index widened by one bit so the compare is never trivially constant,
  // including when NUM_REGS fills the whole address space.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
  endfunction

  assign S_AXI_AWREADY = !ARESET && !aw_held && !bvalid_q;
  assign S_AXI_WREADY  = !ARESET && !w_held && !bvalid_q;
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Address and data each come either from the holding register or from a
  // handshake on this very edge.
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  always_comb begin
    wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    wr_data = w_held ? w_data_q : S_AXI_WDATA;
    wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
    rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == i) rd_word = regs[i];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held      <= 1'b0;
      aw_idx_q     <= '0;
      w_held       <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;

      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;

      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        if (in_range(wr_idx)) begin
          bresp_q <= RESP_OKAY;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(wr_idx) == i) begin
              reg_wr_pulse[i] <= 1'b1;
              for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  // rd_word samples the flops before this edge's write lands, so a read and
  // a write to the same register on one edge returns the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        if (in_range(rd_idx)) begin
          rdata_q <= rd_word;
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpu_axil_slave_regs.sv
// Bench for tpu_axil_slave_regs: a 4-register and a 3-register instance share
// all AXI inputs, so every transaction is checked against both decodes.
module tb_tpu_axil_slave_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a;
  logic [127:0] regq_a;
  logic [3:0]  pulse_a;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b;
  logic [95:0] regq_b;
  logic [2:0]  pulse_b;

  tpu_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut_a (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_a),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
    .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
    .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready),
    .reg_q(regq_a), .reg_wr_pulse(pulse_a)
  );

  tpu_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut_b (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_b),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b),
    .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
    .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready),
    .reg_q(regq_b), .reg_wr_pulse(pulse_b)
  );

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_a;
    logic [1:0]  resp_a;
    logic [31:0] exp_b;
    logic [1:0]  resp_b;
  } vec_t;

  typedef struct {
    logic [31:0] da;
    logic [1:0]  ra;
    logic [31:0] db;
    logic [1:0]  rb;
  } rexp_t;

  typedef struct {
    logic [1:0] ra;
    logic [1:0] rb;
  } bexp_t;

  vec_t  tbl [13];
  rexp_t r_q [$];
  bexp_t b_q [$];
  rexp_t re;
  bexp_t be;

  // Pulse history: each pulse shifts in (index+1) as a nibble.
  logic [31:0] plog_a, plog_b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none (or bound expired)", name);
  endtask

  // Scoreboard monitors: a beat is consumed when VALID and READY are both
  // seen high at the falling edge, i.e. it handshakes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid_a && bready) begin
        if (b_q.size() == 0) fail_now("b_unexpected");
        else begin
          be = b_q.pop_front();
          check("bresp_a", {1'b1, bresp_a}, {1'b1, be.ra});
          check("bresp_b", {bvalid_b, bresp_b}, {1'b1, be.rb});
        end
      end
      if (rvalid_a && rready) begin
        if (r_q.size() == 0) fail_now("r_unexpected");
        else begin
          re = r_q.pop_front();
          check("rdata_a", {rresp_a, rdata_a}, {re.ra, re.da});
          check("rdata_b", {rvalid_b, rresp_b, rdata_b}, {1'b1, re.rb, re.db});
        end
      end
      for (int i = 0; i < 4; i++) if (pulse_a[i]) plog_a = {plog_a[27:0], 4'(i + 1)};
      for (int i = 0; i < 3; i++) if (pulse_b[i]) plog_b = {plog_b[27:0], 4'(i + 1)};
    end
  end

  task automatic start_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
  endtask

  task automatic start_read(input logic [3:0] a);
    araddr = a; arvalid = 1'b1;
  endtask

  // Runs every raised VALID to its handshake, dropping each one after its edge.
  task automatic wait_hs(input string what);
    int cyc = 0;
    bit aw_ok, w_ok, ar_ok;
    while ((awvalid || wvalid || arvalid) && cyc < 50) begin
      @(negedge clk);
      aw_ok = awvalid && awready_a;
      w_ok  = wvalid && wready_a;
      ar_ok = arvalid && arready_a;
      @(posedge clk); #1;
      if (aw_ok) awvalid = 1'b0;
      if (w_ok)  wvalid  = 1'b0;
      if (ar_ok) arvalid = 1'b0;
      cyc++;
    end
    if (awvalid || wvalid || arvalid) begin
      fail_now({"hs_timeout_", what});
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
  endtask

  task automatic drain(input string what);
    int cyc = 0;
    repeat (2) @(negedge clk);
    while ((r_q.size() != 0 || b_q.size() != 0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (r_q.size() != 0 || b_q.size() != 0) begin
      fail_now({"drain_timeout_", what});
      r_q.delete();
      b_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int i);
    if (tbl[i].wr) begin
      b_q.push_back('{tbl[i].resp_a, tbl[i].resp_b});
      start_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
    end else begin
      r_q.push_back('{tbl[i].exp_a, tbl[i].resp_a, tbl[i].exp_b, tbl[i].resp_b});
      start_read(tbl[i].addr);
    end
    wait_hs("vec");
  endtask

  initial begin
    //              wr    addr   data          strb   exp_a         resp_a exp_b         resp_b
    tbl[0]  = '{1'b1, 4'h0, 32'h1,        4'hF, 32'h0,        OK,  32'h0,        OK};
    tbl[1]  = '{1'b1, 4'h4, 32'h2,        4'hF, 32'h0,        OK,  32'h0,        OK};
    tbl[2]  = '{1'b1, 4'h8, 32'h3,        4'hF, 32'h0,        OK,  32'h0,        OK};
    tbl[3]  = '{1'b1, 4'hC, 32'h4,        4'hF, 32'h0,        OK,  32'h0,        ERR};
    tbl[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h1,        OK,  32'h1,        OK};
    tbl[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h2,        OK,  32'h2,        OK};
    tbl[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h3,        OK,  32'h3,        OK};
    tbl[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h4,        OK,  32'h0,        ERR};
    tbl[8]  = '{1'b1, 4'h4, 32'h11223344, 4'hF, 32'h0,        OK,  32'h0,        OK};
    tbl[9]  = '{1'b1, 4'h7, 32'hAABBCCDD, 4'h5, 32'h0,        OK,  32'h0,        OK};
    tbl[10] = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h11BB33DD, OK,  32'h11BB33DD, OK};
    tbl[11] = '{1'b1, 4'h6, 32'hFFFFFFFF, 4'h0, 32'h0,        OK,  32'h0,        OK};
    tbl[12] = '{1'b0, 4'h5, 32'h0,        4'h0, 32'h11BB33DD, OK,  32'h11BB33DD, OK};

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    wdata = '0; wstrb = '0;
    plog_a = '0; plog_b = '0;

    #12;
    check("reset_ctrl_a", {awready_a, wready_a, arready_a, bvalid_a, rvalid_a, bresp_a, rresp_a, pulse_a}, '0);
    check("reset_data_a", {rdata_a, regq_a}, '0);
    check("reset_b", {awready_b, wready_b, arready_b, bvalid_b, rvalid_b, pulse_b, regq_b}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Sequential writes then reads, with out-of-range 0xC on the 3-reg instance.
    for (int i = 0; i < 8; i++) run_vec(i);
    drain("seq");
    check("pulse_order_a", plog_a, 32'h1234);
    check("pulse_order_b", plog_b, 32'h123);
    check("regq_a_seq", regq_a, {32'h4, 32'h3, 32'h2, 32'h1});
    check("regq_b_seq", regq_b, {32'h3, 32'h2, 32'h1});

    // Read and write of reg1 on the same edge: read sees the old value.
    r_q.push_back('{32'h2, OK, 32'h2, OK});
    b_q.push_back('{OK, OK});
    start_read(4'h4);
    start_write(4'h4, 32'h55, 4'hF);
    wait_hs("collide");
    r_q.push_back('{32'h55, OK, 32'h55, OK});
    start_read(4'h4);
    wait_hs("collide_rd");
    drain("collide");

    // Partial strobes and a zero-strobe write that must still pulse.
    plog_a = '0; plog_b = '0;
    for (int i = 8; i < 13; i++) run_vec(i);
    drain("strb");
    check("pulse_strb_a", plog_a, 32'h222);
    check("pulse_strb_b", plog_b, 32'h222);

    // W three cycles ahead of AW.
    b_q.push_back('{OK, OK});
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("w_first_wready", wready_a, 1'b1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("w_held_idle", {awready_a, wready_a, bvalid_a, regq_a[95:64]}, {3'b100, 32'h3});
      @(posedge clk); #1;
    end
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_awready", {awready_a, bvalid_a}, 2'b10);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("aw_late_commit", {bvalid_a, regq_a[95:64]}, {1'b1, 32'hCAFEF00D});
    drain("w_first");

    // BREADY held low: second write must wait for the first response.
    bready = 1'b0;
    b_q.push_back('{OK, OK});
    start_write(4'h0, 32'h10, 4'hF);
    wait_hs("bp_first");
    b_q.push_back('{OK, OK});
    start_write(4'h0, 32'h20, 4'hF);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {bvalid_a, awready_a, wready_a, regq_a[31:0]}, {3'b100, 32'h10});
      @(posedge clk); #1;
    end
    bready = 1'b1;
    wait_hs("bp_second");
    drain("bp");
    check("bp_final", regq_a[31:0], 32'h20);

    // Reset with AW held (W never sent) and a read response pending.
    rready = 1'b0;
    start_read(4'h8);
    awaddr = 4'h8; awvalid = 1'b1;
    wait_hs("pre_reset");
    @(negedge clk);
    check("pre_reset_state", {rvalid_a, awready_a, wready_a}, 3'b101);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_ctrl", {awready_a, wready_a, arready_a, bvalid_a, rvalid_a, pulse_a, rdata_a}, '0);
    check("mid_reset_regs", {regq_a, regq_b}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rready = 1'b1;
    b_q.push_back('{OK, OK});
    start_write(4'h0, 32'h77, 4'hF);
    wait_hs("post_reset_wr");
    r_q.push_back('{32'h77, OK, 32'h77, OK});
    start_read(4'h0);
    wait_hs("post_reset_rd");
    drain("post_reset");
    check("post_reset_regs", regq_a, {96'h0, 32'h77});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
